program_loader: RTL and testbench

//  Byte-stream writer for the instruction memory load port and the register-file preload port.

---
 rtl/loader_pkg.sv | 20 ++
 rtl/loader_chk.sv | 25 ++
 rtl/program_loader.sv | 135 +++++++++++++
 tb/tb_program_loader.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared command codes, frame length and FSM state encoding for the program loader.
package loader_pkg;

  localparam logic [7:0] CMD_INS   = 8'h01;
  localparam logic [7:0] CMD_REG   = 8'h02;
  localparam logic [7:0] CMD_END   = 8'hFF;
  localparam int         FRAME_LEN = 6;

  typedef enum logic [2:0] {
    S_CMD    = 3'd0,
    S_AH     = 3'd1,
    S_AL     = 3'd2,
    S_DH     = 3'd3,
    S_DL     = 3'd4,
    S_CHK    = 3'd5,
    S_COMMIT = 3'd6,
    S_DONE   = 3'd7
  } state_t;

endpackage

// File: rtl/loader_chk.sv
// Running XOR over the first five frame bytes; match compares the incoming CHK byte.
module loader_chk (
  input  logic       clock,
  input  logic       clear,
  input  logic       start,
  input  logic       accum,
  input  logic [7:0] byte_in,
  output logic       match
);

  logic [7:0] acc;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      acc <= '0;
    end else if (start) begin
      acc <= byte_in;
    end else if (accum) begin
      acc <= acc ^ byte_in;
    end
  end

  assign match = (byte_in == acc);

endmodule

// File: rtl/program_loader.sv
// Framed byte-stream loader: state | meaning -- S_CMD..S_CHK | collecting frame bytes,
// S_COMMIT | one-cycle write strobe, S_DONE | core released until clear.
module program_loader
  import loader_pkg::*;
#(
  parameter int IMEM_BYTES = 64,
  parameter int NREGS      = 16
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic [15:0] ins_load,
  output logic [15:0] l_addr,
  output logic        load,
  output logic [15:0] reg_load,
  output logic [3:0]  reg_addr,
  output logic        loadreg,
  output logic        run,
  output logic        error,
  output logic [7:0]  words_done
);

  state_t      state, state_nx;
  logic [7:0]  cmd_q, ahi_q, alo_q, dhi_q, dlo_q;
  logic [15:0] addr_w;
  logic        ready_int;
  logic        chk_start, chk_accum, chk_match, chk_xfer;
  logic        addr_ok, frame_ok;

  assign addr_w    = {ahi_q, alo_q};
  assign chk_start = (state == S_CMD) && byte_valid;
  assign chk_accum = byte_valid && (state inside {S_AH, S_AL, S_DH, S_DL});
  assign chk_xfer  = (state == S_CHK) && byte_valid;

  loader_chk u_chk (
    .clock   (clock),
    .clear   (clear),
    .start   (chk_start),
    .accum   (chk_accum),
    .byte_in (byte_in),
    .match   (chk_match)
  );

  // A register index below NREGS implies a zero A_HI and A_LO[7:4].
  always_comb begin
    addr_ok = 1'b0;
    case (cmd_q)
      CMD_INS: addr_ok = !alo_q[0] && (addr_w <= 16'(IMEM_BYTES - 2));
      CMD_REG: addr_ok = (addr_w <= 16'(NREGS - 1));
      CMD_END: addr_ok = 1'b1;
      default: addr_ok = 1'b0;
    endcase
  end

  assign frame_ok = chk_match && addr_ok;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state <= S_CMD;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    ready_int = 1'b0;
    load      = 1'b0;
    loadreg   = 1'b0;
    run       = 1'b0;
    case (state)
      S_CMD: begin ready_int = 1'b1; if (byte_valid) state_nx = S_AH; end
      S_AH:  begin ready_int = 1'b1; if (byte_valid) state_nx = S_AL; end
      S_AL:  begin ready_int = 1'b1; if (byte_valid) state_nx = S_DH; end
      S_DH:  begin ready_int = 1'b1; if (byte_valid) state_nx = S_DL; end
      S_DL:  begin ready_int = 1'b1; if (byte_valid) state_nx = S_CHK; end
      S_CHK: begin
        ready_int = 1'b1;
        if (byte_valid) state_nx = frame_ok ? S_COMMIT : S_CMD;
      end
      S_COMMIT: begin
        load     = (cmd_q == CMD_INS);
        loadreg  = (cmd_q == CMD_REG);
        state_nx = (cmd_q == CMD_END) ? S_DONE : S_CMD;
      end
      S_DONE:  run = 1'b1;
      default: state_nx = S_CMD;
    endcase
  end

  assign byte_ready = ready_int & clear;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      cmd_q      <= '0;
      ahi_q      <= '0;
      alo_q      <= '0;
      dhi_q      <= '0;
      dlo_q      <= '0;
      l_addr     <= '0;
      ins_load   <= '0;
      reg_addr   <= '0;
      reg_load   <= '0;
      error      <= 1'b0;
      words_done <= '0;
    end else begin
      if (byte_valid) begin
        case (state)
          S_CMD:   cmd_q <= byte_in;
          S_AH:    ahi_q <= byte_in;
          S_AL:    alo_q <= byte_in;
          S_DH:    dhi_q <= byte_in;
          S_DL:    dlo_q <= byte_in;
          default: ;
        endcase
      end
      // Targets are loaded ahead of the strobe so they are stable across the write edge.
      if (chk_xfer) begin
        if (!frame_ok) begin
          error <= 1'b1;
        end else if (cmd_q == CMD_INS) begin
          l_addr   <= addr_w;
          ins_load <= {dhi_q, dlo_q};
          if (words_done != 8'hFF) words_done <= words_done + 8'd1;
        end else if (cmd_q == CMD_REG) begin
          reg_addr <= alo_q[3:0];
          reg_load <= {dhi_q, dlo_q};
        end
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Randomised stream bench for program_loader with a frame-level reference model.
module tb_program_loader;
  import loader_pkg::*;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic [15:0] ins_load, l_addr, reg_load;
  logic [3:0]  reg_addr;
  logic        load, loadreg, run, error;
  logic [7:0]  words_done;

  always #5 clock = ~clock;

  program_loader #(.IMEM_BYTES(64), .NREGS(16)) dut (
    .clock      (clock),
    .clear      (clear),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .ins_load   (ins_load),
    .l_addr     (l_addr),
    .load       (load),
    .reg_load   (reg_load),
    .reg_addr   (reg_addr),
    .loadreg    (loadreg),
    .run        (run),
    .error      (error),
    .words_done (words_done)
  );

  int checks = 0;
  int fails  = 0;

  logic [7:0]  stream[$];
  int          valid_pct = 100;
  logic [7:0]  fb[FRAME_LEN];
  int          idx;
  bit          pend, done, m_err;
  logic [7:0]  last_cmd;
  logic [15:0] m_laddr, m_ins, m_rload;
  logic [3:0]  m_raddr;
  int          m_words;
  int          load_cnt, reg_cnt;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_ready();
    return clear && !pend && !done;
  endfunction

  task automatic model_reset();
    idx = 0; pend = 0; done = 0; m_err = 0; last_cmd = 8'h00;
    m_laddr = 0; m_ins = 0; m_rload = 0; m_raddr = 0; m_words = 0;
  endtask

  task automatic judge();
    logic [7:0]  x;
    logic [15:0] a, d;
    bit ok;
    x = fb[0] ^ fb[1] ^ fb[2] ^ fb[3] ^ fb[4];
    a = {fb[1], fb[2]};
    d = {fb[3], fb[4]};
    ok = (x == fb[5]);
    if (fb[0] == CMD_INS)      ok = ok && (a % 2 == 0) && (a <= 62);
    else if (fb[0] == CMD_REG) ok = ok && (a < 16);
    else if (fb[0] != CMD_END) ok = 0;
    if (!ok) begin
      m_err = 1;
    end else begin
      pend = 1;
      last_cmd = fb[0];
      if (fb[0] == CMD_INS) begin
        m_laddr = a; m_ins = d;
        if (m_words < 255) m_words++;
      end else if (fb[0] == CMD_REG) begin
        m_raddr = a[3:0]; m_rload = d;
      end
    end
  endtask

  task automatic model_step();
    if (!clear || done) return;
    if (pend) begin
      pend = 0;
      if (last_cmd == CMD_END) done = 1;
      return;
    end
    if (byte_valid) begin
      fb[idx] = byte_in;
      idx++;
      void'(stream.pop_front());
      if (idx == FRAME_LEN) begin
        judge();
        idx = 0;
      end
    end
  endtask

  task automatic compare();
    check("byte_ready", 32'(byte_ready), 32'(m_ready()));
    check("load", 32'(load), 32'(pend && last_cmd == CMD_INS));
    check("loadreg", 32'(loadreg), 32'(pend && last_cmd == CMD_REG));
    check("run", 32'(run), 32'(done));
    check("error", 32'(error), 32'(m_err));
    check("words_done", 32'(words_done), 32'(m_words));
    check("l_addr", 32'(l_addr), 32'(m_laddr));
    check("ins_load", 32'(ins_load), 32'(m_ins));
    check("reg_addr", 32'(reg_addr), 32'(m_raddr));
    check("reg_load", 32'(reg_load), 32'(m_rload));
    if (load) load_cnt++;
    if (loadreg) reg_cnt++;
  endtask

  task automatic drive();
    if (stream.size() > 0 && $urandom_range(99) < valid_pct) begin
      byte_valid = 1'b1;
      byte_in    = stream[0];
    end else begin
      byte_valid = 1'b0;
      byte_in    = 8'($urandom);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    @(negedge clock);
    compare();
    drive();
  endtask

  task automatic push_frame(logic [7:0] c, logic [15:0] a, logic [15:0] d, bit badchk);
    logic [7:0] x;
    x = c ^ a[15:8] ^ a[7:0] ^ d[15:8] ^ d[7:0];
    if (badchk) x = x ^ 8'h01;
    stream.push_back(c);
    stream.push_back(a[15:8]);
    stream.push_back(a[7:0]);
    stream.push_back(d[15:8]);
    stream.push_back(d[7:0]);
    stream.push_back(x);
  endtask

  task automatic run_stream(int budget);
    int n;
    n = 0;
    while ((stream.size() > 0 || pend) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (n >= budget) begin
      fails++;
      $display("FAIL run_stream: %0d bytes still queued after limit of %0d cycles", stream.size(), budget);
    end
  endtask

  initial begin
    logic [7:0]  c;
    logic [15:0] a;
    int n;
    model_reset();
    drive();
    repeat (3) tick();
    clear = 1'b1;
    tick();
    check("reset words_done", 32'(words_done), 32'h0);
    check("reset byte_ready", 32'(byte_ready), 32'h1);

    // 1: plain INS frame
    load_cnt = 0;
    push_frame(CMD_INS, 16'h0002, 16'h3013, 0);
    run_stream(100);
    check("t1 l_addr", 32'(l_addr), 32'h0002);
    check("t1 ins_load", 32'(ins_load), 32'h3013);
    check("t1 load pulses", 32'(load_cnt), 32'd1);
    check("t1 words_done", 32'(words_done), 32'd1);
    check("t1 error", 32'(error), 32'd0);

    // 2: REG frame
    load_cnt = 0; reg_cnt = 0;
    push_frame(CMD_REG, 16'h0005, 16'h000B, 0);
    run_stream(100);
    check("t2 reg_addr", 32'(reg_addr), 32'h5);
    check("t2 reg_load", 32'(reg_load), 32'h000B);
    check("t2 loadreg pulses", 32'(reg_cnt), 32'd1);
    check("t2 load pulses", 32'(load_cnt), 32'd0);

    // 3: bad checksum, then a good frame
    load_cnt = 0;
    push_frame(CMD_INS, 16'h0002, 16'h3013, 1);
    run_stream(100);
    check("t3 load pulses", 32'(load_cnt), 32'd0);
    check("t3 error", 32'(error), 32'd1);
    push_frame(CMD_INS, 16'h0004, 16'h1234, 0);
    run_stream(100);
    check("t3 recover l_addr", 32'(l_addr), 32'h0004);
    check("t3 recover words", 32'(words_done), 32'd2);

    // 4: odd and out-of-range addresses
    load_cnt = 0;
    push_frame(CMD_INS, 16'h0003, 16'hAAAA, 0);
    push_frame(CMD_INS, 16'h0040, 16'h5555, 0);
    run_stream(100);
    check("t4 load pulses", 32'(load_cnt), 32'd0);
    check("t4 words_done", 32'(words_done), 32'd2);
    check("t4 error", 32'(error), 32'd1);

    // 6: clear in the middle of D_LO with a stalling source
    valid_pct = 50;
    push_frame(CMD_INS, 16'h0006, 16'hBEEF, 0);
    n = 0;
    while (idx != 4 && n < 200) begin tick(); n++; end
    check("t6 reached S_DL", 32'(idx), 32'd4);
    clear = 1'b0;
    byte_valid = 1'b0;
    stream.delete();
    model_reset();
    #1;
    compare();
    check("t6 words after clear", 32'(words_done), 32'd0);
    load_cnt = 0;
    repeat (2) tick();
    clear = 1'b1;
    push_frame(CMD_INS, 16'h000A, 16'h0F0F, 0);
    run_stream(200);
    check("t6 reload l_addr", 32'(l_addr), 32'h000A);
    check("t6 reload pulses", 32'(load_cnt), 32'd1);

    // random mix of good and bad frames with random stalls
    for (int f = 0; f < 60; f++) begin
      valid_pct = $urandom_range(30, 100);
      case ($urandom_range(5))
        0, 1: push_frame(CMD_INS, 16'(2 * $urandom_range(31)), 16'($urandom), 0);
        2:    push_frame(CMD_REG, 16'($urandom_range(15)), 16'($urandom), 0);
        3:    push_frame($urandom_range(1) ? CMD_INS : CMD_REG, 16'($urandom_range(15)), 16'($urandom), 1);
        4: begin
          a = $urandom_range(1) ? 16'($urandom_range(16, 65535)) : 16'(2 * $urandom_range(31) + 1);
          push_frame($urandom_range(1) ? CMD_INS : CMD_REG, a, 16'($urandom), 0);
        end
        default: begin
          c = 8'($urandom_range(3, 254));
          push_frame(c, 16'($urandom_range(62)), 16'($urandom), 0);
        end
      endcase
      run_stream(400);
    end

    // words_done saturation
    valid_pct = 100;
    for (int f = 0; f < 260; f++) push_frame(CMD_INS, 16'h003E, 16'(f), 0);
    run_stream(5000);
    check("sat words_done", 32'(words_done), 32'd255);
    check("sat l_addr", 32'(l_addr), 32'h003E);

    // 5: END frame, then bytes that must be ignored
    push_frame(CMD_END, 16'h0000, 16'h0000, 0);
    run_stream(100);
    check("t5 run", 32'(run), 32'd1);
    check("t5 byte_ready", 32'(byte_ready), 32'd0);
    push_frame(CMD_INS, 16'h0000, 16'h1111, 0);
    load_cnt = 0;
    repeat (12) tick();
    check("t5 ignored load", 32'(load_cnt), 32'd0);
    check("t5 still run", 32'(run), 32'd1);
    stream.delete();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
